// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp step generator and the cyclic_lamp side:
// run/pause state encoding, speed switch codes and the speed-to-shift helper.
package lamp_pkg;

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } lamp_state_t;

  typedef enum logic [1:0] {
    SPD_SLOWEST = 2'd0,
    SPD_SLOW    = 2'd1,
    SPD_FAST    = 2'd2,
    SPD_FASTEST = 2'd3
  } speed_t;

  // Each step down from the fastest setting doubles the step period.
  function automatic logic [1:0] speedShift(input logic [1:0] spd);
    return 2'(SPD_FASTEST) - spd;
  endfunction

endpackage

// File: rtl/lamp_step_gen_if.sv
// Button, speed and step-output bundle between the board-facing logic and
// the step generator.
interface lamp_step_gen_if;
  logic       btn_run;
  logic       btn_step;
  logic [1:0] speed;
  logic       step_tick;
  logic       lamp_clk;
  logic       running;

  modport master (
    output btn_run, btn_step, speed,
    input  step_tick, lamp_clk, running
  );

  modport slave (
    input  btn_run, btn_step, speed,
    output step_tick, lamp_clk, running
  );
endinterface

// File: rtl/lamp_step_gen_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter, debounced
// level and a one-cycle press pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             syncMeta_q;
  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic             stableDly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      syncMeta_q  <= 1'b0;
      sync_q      <= 1'b0;
      stable_q    <= 1'b0;
      stableDly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      syncMeta_q  <= btn_i;
      sync_q      <= syncMeta_q;
      stable_q    <= stable_d;
      stableDly_q <= stable_q;
      press_q     <= stable_q & ~stableDly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/lamp_step_gen.sv
// Step-rate generator for cyclic_lamp: run/pause FSM, speed-scaled prescaler,
// single-step and a stretched lamp_clk pulse with one rising edge per step.
module lamp_step_gen
  import lamp_pkg::*;
#(
  parameter int BASE_DIV     = 25_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int PULSE_W      = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  lamp_step_gen_if.slave bus
);

  localparam int CNT_W  = $clog2(8 * BASE_DIV);
  localparam int WIDE_W = CNT_W + 1;
  localparam int PW_W   = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  logic              runPress;
  logic              stepPress;
  lamp_state_t       state_q;
  lamp_state_t       state_d;
  logic [CNT_W-1:0]  presc_q;
  logic [CNT_W-1:0]  presc_d;
  logic              tick_q;
  logic              tick_d;
  logic              lamp_q;
  logic              lamp_d;
  logic [PW_W-1:0]   pulseCnt_q;
  logic [PW_W-1:0]   pulseCnt_d;
  logic [WIDE_W-1:0] periodWide;
  logic [CNT_W-1:0]  periodM1;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_runDb (
    .clock   (clock),
    .reset_n (reset_n),
    .btn_i   (bus.btn_run),
    .press_o (runPress)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_stepDb (
    .clock   (clock),
    .reset_n (reset_n),
    .btn_i   (bus.btn_step),
    .press_o (stepPress)
  );

  // Speed is taken live, so a shortened period can fire immediately.
  assign periodWide = WIDE_W'(BASE_DIV) << speedShift(bus.speed);
  assign periodM1   = CNT_W'(periodWide - 1'b1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PAUSED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (runPress) begin
      state_d = (state_q == PAUSED) ? RUNNING : PAUSED;
    end
  end

  always_comb begin
    bus.running = (state_q == RUNNING);
  end

  // A run press always wins: it restarts the prescaler and swallows any step.
  always_comb begin
    presc_d = '0;
    tick_d  = 1'b0;
    if (!runPress) begin
      if (state_q == RUNNING) begin
        if (presc_q >= periodM1) begin
          tick_d = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end else begin
        tick_d = stepPress;
      end
    end
  end

  always_comb begin
    lamp_d     = lamp_q;
    pulseCnt_d = pulseCnt_q;
    if (tick_q) begin
      lamp_d     = 1'b1;
      pulseCnt_d = PW_W'(PULSE_W - 1);
    end else if (lamp_q) begin
      if (pulseCnt_q == '0) begin
        lamp_d = 1'b0;
      end else begin
        pulseCnt_d = pulseCnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      lamp_q     <= 1'b0;
      pulseCnt_q <= '0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      lamp_q     <= lamp_d;
      pulseCnt_q <= pulseCnt_d;
    end
  end

  assign bus.step_tick = tick_q;
  assign bus.lamp_clk  = lamp_q;

endmodule

// File: tb/tb_lamp_step_gen.sv
// Directed and randomized checks of lamp_step_gen against a behavioural model
// built from button histories, step periods and tick timestamps.
module tb_lamp_step_gen;
  import lamp_pkg::*;

  localparam int BASE_DIV     = 10;
  localparam int DEBOUNCE_CYC = 4;
  localparam int PULSE_W      = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  lamp_step_gen_if busIf ();

  lamp_step_gen #(
    .BASE_DIV     (BASE_DIV),
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .PULSE_W      (PULSE_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (busIf.slave)
  );

  always #5 clock = ~clock;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int          tickCount  = 0;

  int mEdge;
  bit rawHist[2][$];
  bit mAcc[2];
  bit mPressNext[2];
  bit mPress[2];
  bit mRun;
  bit mTick;
  bit mLamp;
  int mCount;
  int mLastTick;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit rawAt(input int b, input int k);
    if (k < 1 || k > rawHist[b].size()) return 1'b0;
    return rawHist[b][k-1];
  endfunction

  task automatic modelReset();
    mEdge = 0;
    for (int b = 0; b < 2; b++) begin
      rawHist[b].delete();
      mAcc[b]       = 1'b0;
      mPressNext[b] = 1'b0;
      mPress[b]     = 1'b0;
    end
    mRun      = 1'b0;
    mTick     = 1'b0;
    mLamp     = 1'b0;
    mCount    = 0;
    mLastTick = -1000;
  endtask

  // A button level is accepted once the 2-cycle-delayed raw value has
  // disagreed with the accepted level for DEBOUNCE_CYC consecutive edges.
  task automatic modelEdge(input bit r, input bit s, input int spd);
    bit oldPress[2];
    bit allDiffer;
    bit newTick;
    int per;
    mEdge++;
    for (int b = 0; b < 2; b++) begin
      oldPress[b]   = mPress[b];
      mPress[b]     = mPressNext[b];
      mPressNext[b] = 1'b0;
      rawHist[b].push_back(b == 0 ? r : s);
      allDiffer = 1'b1;
      for (int j = 0; j < DEBOUNCE_CYC; j++)
        if (rawAt(b, mEdge - 2 - j) == mAcc[b]) allDiffer = 1'b0;
      if (allDiffer) begin
        mAcc[b] = !mAcc[b];
        if (mAcc[b]) mPressNext[b] = 1'b1;
      end
    end
    per     = BASE_DIV * (1 << (3 - spd));
    newTick = 1'b0;
    if (oldPress[0]) begin
      mRun   = !mRun;
      mCount = 0;
    end else if (mRun) begin
      if (mCount >= per - 1) begin
        newTick = 1'b1;
        mCount  = 0;
      end else begin
        mCount++;
      end
    end else begin
      mCount  = 0;
      newTick = oldPress[1];
    end
    mLamp = (mEdge - mLastTick >= 1) && (mEdge - mLastTick <= PULSE_W);
    mTick = newTick;
    if (newTick) mLastTick = mEdge;
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, "_tick"},    busIf.step_tick, mTick);
    cmp({tag, "_lamp"},    busIf.lamp_clk,  mLamp);
    cmp({tag, "_running"}, busIf.running,   mRun);
  endtask

  task automatic applyStimulus(input bit r, input bit s, input int spd);
    busIf.btn_run  = r;
    busIf.btn_step = s;
    busIf.speed    = 2'(spd);
    @(posedge clock);
    modelEdge(r, s, spd);
    #1;
    if (busIf.step_tick === 1'b1) tickCount++;
    checkOutput("model");
  endtask

  initial begin
    logic anyHigh;
    logic found;
    bit   rRun;
    bit   rStep;
    int   spd;

    busIf.btn_run  = 1'b0;
    busIf.btn_step = 1'b0;
    busIf.speed    = 2'd3;
    modelReset();
    repeat (3) @(posedge clock);
    #1;
    cmp("reset_tick",    busIf.step_tick, 0);
    cmp("reset_lamp",    busIf.lamp_clk,  0);
    cmp("reset_running", busIf.running,   0);
    #2 reset_n = 1'b1;
    modelReset();
    $display("[TB] reset released, idling");

    anyHigh = 1'b0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, 1'b0, 3);
      if (busIf.step_tick !== 1'b0 || busIf.lamp_clk !== 1'b0 || busIf.running !== 1'b0)
        anyHigh = 1'b1;
    end
    cmp("idle_quiet", anyHigh, 0);

    $display("[TB] run press at fastest speed");
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(i <= 10, 1'b0, 3);
      if (i == 7) cmp("run_before_latency", busIf.running, 0);
      if (i == 8) cmp("run_at_latency", busIf.running, 1);
      if (i == 18 || i == 28 || i == 38) cmp("run_tick_period", busIf.step_tick, 1);
      if (i == 19 || i == 20) cmp("lamp_pulse_high", busIf.lamp_clk, 1);
      if (i == 21) cmp("lamp_pulse_end", busIf.lamp_clk, 0);
    end

    $display("[TB] speed change slowest to fastest");
    tickCount = 0;
    for (int i = 0; i < 48; i++) applyStimulus(1'b0, 1'b0, 0);
    cmp("slow_no_tick", tickCount, 0);
    applyStimulus(1'b0, 1'b0, 3);
    cmp("speed_up_tick", busIf.step_tick, 1);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b0, 3);
      if (i == 10) cmp("speed_up_period", busIf.step_tick, 1);
    end

    $display("[TB] pause");
    tickCount = 0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(i <= 10, 1'b0, 3);
      if (i == 8) cmp("pause_running", busIf.running, 0);
    end
    cmp("pause_no_tick", tickCount, 0);

    $display("[TB] single step and bounce");
    tickCount = 0;
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(1'b0, i <= 8, 3);
      if (i == 8) cmp("step_tick_latency", busIf.step_tick, 1);
    end
    cmp("step_single_tick", tickCount, 1);
    tickCount = 0;
    for (int i = 1; i <= 20; i++) applyStimulus(1'b0, (i <= 3) && (i % 2 == 1), 3);
    cmp("step_bounce_no_tick", tickCount, 0);

    $display("[TB] simultaneous run and step");
    tickCount = 0;
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(i <= 10, i <= 10, 3);
      if (i == 8)  cmp("simul_running", busIf.running, 1);
      if (i == 17) cmp("simul_no_entry_tick", tickCount, 0);
      if (i == 18) cmp("simul_first_tick", busIf.step_tick, 1);
    end

    $display("[TB] reset during lamp pulse");
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      applyStimulus(1'b0, 1'b0, 3);
      if (busIf.lamp_clk === 1'b1) found = 1'b1;
    end
    cmp("wait_lamp_high", found, 1);
    #2 reset_n = 1'b0;
    #1;
    cmp("rst_async_tick",    busIf.step_tick, 0);
    cmp("rst_async_lamp",    busIf.lamp_clk,  0);
    cmp("rst_async_running", busIf.running,   0);
    modelReset();
    repeat (3) begin
      @(posedge clock);
      #1;
      cmp("rst_hold_lamp",    busIf.lamp_clk, 0);
      cmp("rst_hold_running", busIf.running,  0);
    end
    #2 reset_n = 1'b1;
    modelReset();
    tickCount = 0;
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 3);
    cmp("post_reset_no_tick", tickCount, 0);
    cmp("post_reset_paused", busIf.running, 0);

    $display("[TB] button held through reset release");
    busIf.btn_run = 1'b1;
    #2 reset_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    modelReset();
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b1, 1'b0, 3);
      if (i == 7) cmp("held_before_press", busIf.running, 0);
      if (i == 8) cmp("held_press_running", busIf.running, 1);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 3);

    $display("[TB] randomized buttons and speed");
    rRun  = 1'b0;
    rStep = 1'b0;
    spd   = 3;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) rRun = !rRun;
      if ($urandom_range(0, 7) == 0) rStep = !rStep;
      if ($urandom_range(0, 59) == 0) spd = int'($urandom_range(0, 3));
      applyStimulus(rRun, rStep, spd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
